trig_type_lv1a_ext_multi: RTL and testbench
===========================================

TRIG_TYPE_LV1A_EXT_MULTI -- requirements
Module: trig_type_lv1a_ext_multi

Interface
REQ-001 Parameter NCH, default 4, SHALL set the number of external trigger channels (1..16).
REQ-002 Parameter CW, default 16, SHALL set the per-channel raw/accepted counter width.
REQ-003 Parameter PSW, default 8, SHALL set the per-channel prescale field width.
REQ-004 Parameter HOLDOFF, default 4, SHALL set the post-trigger holdoff in clk cycles (0 = none).
REQ-005 Ports SHALL be:
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous active-high reset
- in_ext  in  NCH  external trigger levels, synchronous to clk
- in_live  in  1  DAQ live
- in_ena  in  1  global trigger enable
- in_spill  in  1  beam spill flag
- user_ena  in  NCH  per-channel enable
- user_spill_on  in  NCH  channel allowed in spill
- user_spill_off  in  NCH  channel allowed off spill
- user_prescale  in  NCH*PSW  channel i at [i*PSW +: PSW]
- out_lv1a  out  1  level-1 accept pulse
- out_type  out  NCH  channels accepted in that pulse
- raw_cnt  out  NCH*CW  qualified edges per channel, channel i at [i*CW +: CW]
- acc_cnt  out  NCH*CW  accepted triggers per channel, same packing

Function
REQ-006 Channel i SHALL detect an edge when in_ext[i]=1 in the current cycle and 0 in the previous cycle; a held level produces one edge only.
REQ-007 An edge SHALL qualify iff user_ena[i], in_ena and in_live are 1, and either (user_spill_on[i] and in_spill=1) or (user_spill_off[i] and in_spill=0).
REQ-008 Each qualified edge SHALL increment raw_cnt[i], including during holdoff.
REQ-009 Outside holdoff, a qualified edge SHALL advance the channel prescaler; the channel accepts when the prescaler reaches max(P,1)-1, P = user_prescale[i], and then wraps to 0 (P=0 or 1: accept every edge).
REQ-010 Acceptance of any channel in cycle n SHALL assert out_lv1a for exactly one cycle at n+1, with out_type = mask of all channels accepted in cycle n, and increment acc_cnt of each of those channels.
REQ-011 The control FSM SHALL have states IDLE and HOLD: IDLE->HOLD on any acceptance when HOLDOFF>0; HOLD counts HOLDOFF cycles, then returns to IDLE; acceptance is only possible in IDLE.
REQ-012 During HOLD the prescalers SHALL NOT advance and out_lv1a SHALL remain 0.
REQ-013 Counters SHALL saturate at all-ones, never wrap.
REQ-014 On an in_live 0->1 transition, raw_cnt, acc_cnt and prescalers of all channels SHALL clear; a qualified edge in the same cycle SHALL count from zero (count = 1 after that cycle).
REQ-015 Counters SHALL hold their value while in_live=0 so they can be read during live off.
REQ-016 out_type SHALL be 0 whenever out_lv1a is 0.

Reset
REQ-017 While rst=1: out_lv1a=0, out_type=0, raw_cnt=0, acc_cnt=0, prescalers=0, edge history=0, previous live=0, FSM=IDLE, holdoff counter=0.
REQ-018 Reset asserted mid-HOLD or mid-pulse SHALL abort immediately; the first edge after deassertion SHALL require in_ext low->high seen after reset.

Configuration
REQ-019 With TRIG_EXT_PRESCALE_EN defined, prescaling SHALL behave per REQ-009; without it, user_prescale SHALL be ignored, no prescaler registers SHALL exist, and every qualified edge outside holdoff SHALL be accepted.

Structure
REQ-020 Package trig_pkg SHALL hold the FSM state type (IDLE, HOLD) and default values of NCH, CW, PSW, HOLDOFF.
REQ-021 Per-channel edge detect, qualification, prescaler and counters SHALL be sub-module trig_ext_chan, instantiated NCH times; holdoff FSM and output merge stay in the top.

Verification
REQ-022 NCH=4, P=0, HOLDOFF=0, all enabled, live=1: single edge on ch2 -> out_lv1a pulse one cycle later, out_type=4'b0100, raw_cnt[2]=acc_cnt[2]=1.
REQ-023 ch0 P=3, 9 edges spaced 10 cycles -> raw_cnt[0]=9, acc_cnt[0]=3, pulses on edges 3,6,9 (macro defined); 9 pulses without macro.
REQ-024 HOLDOFF=4, ch0 edges at cycles 0 and 2, ch1 edge at cycle 6 -> pulses at 1 and 7 only, raw_cnt[0]=2, acc_cnt[0]=1, acc_cnt[1]=1.
REQ-025 user_spill_on=1, user_spill_off=0: edges with in_spill=0 -> no pulse, raw_cnt unchanged; in_spill=1 -> pulses; simultaneous ch1+ch3 edges -> one pulse, out_type=4'b1010.
REQ-026 CW=4: 20 accepted edges -> counters stick at 15; live 1->0->1 with edge on rising cycle -> counters read 1; rst mid-HOLD -> all outputs 0 next cycle.

Source files
------------

// File: rtl/trig_pkg.sv
// trig_pkg: shared FSM state type and default parameters for the external trigger block
package trig_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam int NCH_DEF     = 4;
  localparam int CW_DEF      = 16;
  localparam int PSW_DEF     = 8;
  localparam int HOLDOFF_DEF = 4;
endpackage

// File: rtl/trig_ext_chan.sv
// trig_ext_chan: one external channel (edge detect, qualification, prescale, saturating counters)
// Prescaler exists only when TRIG_EXT_PRESCALE_EN is defined.
module trig_ext_chan #(
  parameter int CW  = 16,
  parameter int PSW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ext,
  input  logic           ena,
  input  logic           gena,
  input  logic           live,
  input  logic           clr,
  input  logic           spill,
  input  logic           son,
  input  logic           soff,
  input  logic           idle,
  input  logic [PSW-1:0] ps,
  output logic           acc,
  output logic [CW-1:0]  raw_cnt,
  output logic [CW-1:0]  acc_cnt
);
  logic ext_q, arm, qual;
  // arm blocks a level that was already high at reset release from counting as an edge
  assign qual = ext & ~ext_q & arm & ena & gena & live & ((son & spill) | (soff & ~spill));
`ifdef TRIG_EXT_PRESCALE_EN
  logic [PSW-1:0] psc, psc_c, lim;
  logic adv;
  assign lim   = (ps == '0) ? '0 : ps - 1'b1;
  assign psc_c = clr ? '0 : psc;
  assign adv   = qual & idle;
  assign acc   = adv & (psc_c == lim);
  always_ff @(posedge clk or posedge rst)
    if (rst) psc <= '0;
    else if (clr || adv) psc <= adv ? (acc ? '0 : psc_c + 1'b1) : '0;
`else
  logic unused_ps;
  assign unused_ps = ^ps;
  assign acc = qual & idle;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ext_q   <= 1'b0;
      arm     <= 1'b0;
      raw_cnt <= '0;
      acc_cnt <= '0;
    end else begin
      ext_q   <= ext;
      arm     <= arm | ~ext;
      raw_cnt <= clr ? CW'(qual) : (qual && !(&raw_cnt)) ? raw_cnt + 1'b1 : raw_cnt;
      acc_cnt <= clr ? CW'(acc) : (acc && !(&acc_cnt)) ? acc_cnt + 1'b1 : acc_cnt;
    end
endmodule

// File: rtl/trig_type_lv1a_ext_multi.sv
// trig_type_lv1a_ext_multi: multi-channel external LV1A trigger with holdoff and per-channel counters
// Optional per-channel prescaling is enabled by defining TRIG_EXT_PRESCALE_EN.
module trig_type_lv1a_ext_multi
  import trig_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int CW      = CW_DEF,
  parameter int PSW     = PSW_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    in_ext,
  input  logic              in_live,
  input  logic              in_ena,
  input  logic              in_spill,
  input  logic [NCH-1:0]    user_ena,
  input  logic [NCH-1:0]    user_spill_on,
  input  logic [NCH-1:0]    user_spill_off,
  input  logic [NCH*PSW-1:0] user_prescale,
  output logic              out_lv1a,
  output logic [NCH-1:0]    out_type,
  output logic [NCH*CW-1:0] raw_cnt,
  output logic [NCH*CW-1:0] acc_cnt
);
  localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
  state_t state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [NCH-1:0] acc;
  logic live_q, clr, idle;
  assign clr  = in_live & ~live_q;
  assign idle = state == IDLE;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    trig_ext_chan #(.CW(CW), .PSW(PSW)) u_ch (
      .clk(clk), .rst(rst), .ext(in_ext[i]), .ena(user_ena[i]), .gena(in_ena),
      .live(in_live), .clr(clr), .spill(in_spill), .son(user_spill_on[i]),
      .soff(user_spill_off[i]), .idle(idle), .ps(user_prescale[i*PSW +: PSW]),
      .acc(acc[i]), .raw_cnt(raw_cnt[i*CW +: CW]), .acc_cnt(acc_cnt[i*CW +: CW])
    );
  end
  always_comb begin
    state_n = state;
    hcnt_n  = '0;
    if (idle) state_n = (|acc && HOLDOFF > 0) ? HOLD : IDLE;
    else begin
      state_n = (int'(hcnt) == HOLDOFF - 1) ? IDLE : HOLD;
      hcnt_n  = (state_n == HOLD) ? hcnt + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      live_q   <= 1'b0;
      out_lv1a <= 1'b0;
      out_type <= '0;
    end else begin
      state    <= state_n;
      hcnt     <= hcnt_n;
      live_q   <= in_live;
      out_lv1a <= |acc;
      out_type <= acc;
    end
endmodule

// File: tb/tb_trig_type_lv1a_ext_multi.sv
// tb_trig_type_lv1a_ext_multi: scoreboard bench for the external LV1A trigger (CW=4, HOLDOFF=4)
module tb_trig_type_lv1a_ext_multi;
  logic clk = 0, rst = 1;
  logic [3:0] in_ext = 0, user_ena = 4'hF, user_spill_on = 4'hF, user_spill_off = 4'hF;
  logic in_live = 0, in_ena = 1, in_spill = 0;
  logic [31:0] user_prescale = 0;
  logic out_lv1a;
  logic [3:0] out_type;
  logic [15:0] raw_cnt, acc_cnt;
  logic [3:0] sb[$];
  int n_cmp = 0, n_bad = 0;
`ifdef TRIG_EXT_PRESCALE_EN
  localparam int A0 = 3;
`else
  localparam int A0 = 9;
`endif

  trig_type_lv1a_ext_multi #(.NCH(4), .CW(4), .PSW(8), .HOLDOFF(4)) dut (
    .clk(clk), .rst(rst), .in_ext(in_ext), .in_live(in_live), .in_ena(in_ena),
    .in_spill(in_spill), .user_ena(user_ena), .user_spill_on(user_spill_on),
    .user_spill_off(user_spill_off), .user_prescale(user_prescale),
    .out_lv1a(out_lv1a), .out_type(out_type), .raw_cnt(raw_cnt), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  function automatic logic [3:0] raw(int i); return raw_cnt[i*4 +: 4]; endfunction
  function automatic logic [3:0] acn(int i); return acc_cnt[i*4 +: 4]; endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(logic [3:0] m, int gap);
    in_ext = m;
    cyc(1);
    in_ext = 0;
    cyc(gap);
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (out_lv1a) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got type %b required no pulse", out_type);
        end else chk("out_type", 32'(out_type), 32'(sb.pop_front()));
      end else chk("idle_type", 32'(out_type), 0);
    end

  initial begin
    logic [3:0] hv[8];
    hv = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
    cyc(2);
    chk("rst_lv1a", 32'(out_lv1a), 0);
    chk("rst_type", 32'(out_type), 0);
    chk("rst_raw", 32'(raw_cnt), 0);
    chk("rst_acc", 32'(acc_cnt), 0);
    rst = 0;
    in_live = 1;
    cyc(3);
    sb.push_back(4'b0100);
    pulse(4'b0100, 8);
    chk("single_raw2", 32'(raw(2)), 1);
    chk("single_acc2", 32'(acn(2)), 1);
    user_prescale[7:0] = 3;
    for (int k = 0; k < 9; k++) begin
`ifdef TRIG_EXT_PRESCALE_EN
      if (k % 3 == 2) sb.push_back(4'b0001);
`else
      sb.push_back(4'b0001);
`endif
      pulse(4'b0001, 10);
    end
    chk("psc_raw0", 32'(raw(0)), 9);
    chk("psc_acc0", 32'(acn(0)), A0);
    user_prescale = 0;
    sb.push_back(4'b0001);
    sb.push_back(4'b0010);
    foreach (hv[k]) begin
      in_ext = hv[k];
      cyc(1);
    end
    in_ext = 0;
    cyc(6);
    chk("hold_raw0", 32'(raw(0)), 11);
    chk("hold_acc0", 32'(acn(0)), A0 + 1);
    chk("hold_acc1", 32'(acn(1)), 1);
    user_spill_off = 0;
    in_spill = 0;
    pulse(4'b1000, 8);
    chk("offspill_raw3", 32'(raw(3)), 0);
    in_spill = 1;
    sb.push_back(4'b1010);
    pulse(4'b1010, 8);
    chk("spill_raw3", 32'(raw(3)), 1);
    chk("spill_acc3", 32'(acn(3)), 1);
    chk("spill_raw1", 32'(raw(1)), 2);
    chk("spill_acc1", 32'(acn(1)), 2);
    for (int k = 0; k < 20; k++) begin
      sb.push_back(4'b0100);
      pulse(4'b0100, 7);
    end
    chk("sat_raw2", 32'(raw(2)), 15);
    chk("sat_acc2", 32'(acn(2)), 15);
    in_live = 0;
    cyc(3);
    pulse(4'b0100, 5);
    chk("liveoff_raw2", 32'(raw(2)), 15);
    chk("liveoff_raw0", 32'(raw(0)), 11);
    in_live = 1;
    sb.push_back(4'b0100);
    pulse(4'b0100, 6);
    chk("liverise_raw2", 32'(raw(2)), 1);
    chk("liverise_acc2", 32'(acn(2)), 1);
    chk("liverise_raw0", 32'(raw(0)), 0);
    chk("liverise_acc1", 32'(acn(1)), 0);
    sb.push_back(4'b0001);
    pulse(4'b0001, 2);
    rst = 1;
    #1;
    chk("midhold_lv1a", 32'(out_lv1a), 0);
    chk("midhold_type", 32'(out_type), 0);
    chk("midhold_raw", 32'(raw_cnt), 0);
    chk("midhold_acc", 32'(acc_cnt), 0);
    in_ext = 4'b0001;
    cyc(3);
    rst = 0;
    cyc(5);
    chk("heldhigh_raw0", 32'(raw(0)), 0);
    in_ext = 0;
    cyc(1);
    sb.push_back(4'b0001);
    pulse(4'b0001, 6);
    chk("post_rst_raw0", 32'(raw(0)), 1);
    chk("post_rst_acc0", 32'(acn(0)), 1);
    chk("sb_leftover", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
